// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte buffer behind a UART receiver.
// Bytes strobed in on i_wr_valid are queued and drained over o_rd_valid/i_rd_ready.
// A write into a full FIFO is dropped unless a pop happens in the same cycle.
// Dropped bytes set a sticky overflow flag and bump a saturating drop counter.
module uart_rx_fifo #(
   parameter  int DEPTH = 16,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [7:0]       i_wr_data,
   input  logic             i_wr_valid,
   output logic [7:0]       o_rd_data,
   output logic             o_rd_valid,
   input  logic             i_rd_ready,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_overflow,
   input  logic             i_ovf_clear,
   output logic [7:0]       o_drop_cnt
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [7:0]       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wp;
   logic [PTR_W-1:0] r_rp;
   logic [CNT_W-1:0] r_count;
   logic             r_overflow;
   logic [7:0]       r_drop_cnt;

   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;

   // Status decode and push/pop/drop qualification from the registered count
   always_comb begin
      w_full  = (r_count == CNT_W'(DEPTH));
      w_empty = (r_count == {CNT_W{1'b0}});
      w_pop   = ~w_empty & i_rd_ready;
      w_push  = i_wr_valid & (~w_full | w_pop);
      w_drop  = i_wr_valid & w_full & ~w_pop;
   end

   // Byte storage; not reset, and writes are suppressed while reset is held
   always_ff @(posedge i_clk) begin
      if (i_rst_n && w_push) begin
         r_mem[r_wp] <= i_wr_data;
      end
   end

   // Pointers and fill level; pointers wrap naturally at DEPTH
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wp    <= {PTR_W{1'b0}};
         r_rp    <= {PTR_W{1'b0}};
         r_count <= {CNT_W{1'b0}};
      end else begin
         if (w_push) begin
            r_wp <= r_wp + PTR_W'(1);
         end
         if (w_pop) begin
            r_rp <= r_rp + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky overflow flag and saturating drop counter; a drop beats a clear
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= 8'h00;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (i_ovf_clear) begin
            r_drop_cnt <= 8'h01;
         end else if (r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 8'h01;
         end
      end else if (i_ovf_clear) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= 8'h00;
      end
   end

   // Output drive; head byte is forced to zero while the FIFO is empty
   always_comb begin
      o_rd_valid = ~w_empty;
      if (w_empty) begin
         o_rd_data = 8'h00;
      end else begin
         o_rd_data = r_mem[r_rp];
      end
      o_count    = r_count;
      o_full     = w_full;
      o_empty    = w_empty;
      o_overflow = r_overflow;
      o_drop_cnt = r_drop_cnt;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. Captures each byte the receiver announces with its single-cycle `valid` strobe and holds it in a first-word-fall-through FIFO. The FIFO drains over a ready/valid interface to the consuming logic. Reports fill level, flags overflow stickily, and counts dropped bytes so software or a parser can detect lost characters.

## Interface

Parameters:
- `DEPTH`, default 16: number of byte entries; power of two, minimum 2.
- `CNT_W`, default `$clog2(DEPTH)+1`: width of `count`; derived, not overridden.

Ports:
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst_n`  input  1  synchronous, active-low reset, sampled on rising `clk`.
- `wr_data`  input  8  byte from the receiver (`rx_data`).
- `wr_valid`  input  1  one-cycle write strobe (receiver `valid`); no backpressure to the receiver.
- `rd_data`  output  8  head-of-FIFO byte; `8'h00` whenever `rd_valid`=0.
- `rd_valid`  output  1  FIFO non-empty; `rd_data` is valid.
- `rd_ready`  input  1  consumer accepts head byte; pop occurs when `rd_valid & rd_ready`.
- `count`  output  CNT_W  number of stored bytes, 0..DEPTH.
- `full`  output  1  `count == DEPTH`.
- `empty`  output  1  `count == 0`.
- `overflow`  output  1  sticky; set when a byte is dropped.
- `ovf_clear`  input  1  clears `overflow` and `drop_cnt`.
- `drop_cnt`  output  8  saturating count of dropped bytes (stops at 255).

## Operation

- Storage: DEPTH×8 register array, write pointer `wp` and read pointer `rp`, each `$clog2(DEPTH)` bits. Pointers wrap modulo DEPTH by natural overflow. The array is not reset.
- Pop: `pop = rd_valid & rd_ready`. On pop, `rp` increments.
- Push: `push = wr_valid & (~full | pop)`. On push, `mem[wp] <= wr_data` and `wp` increments.
- Count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Drop: `wr_valid & full & ~pop` discards `wr_data`. No state changes except the following:
  - `overflow` <= 1.
  - `drop_cnt` increments unless it is already 255.
- Full with simultaneous write and pop: the write is accepted, not dropped. Count stays DEPTH.
- Empty with write and `rd_ready` in the same cycle: there is no bypass. The byte is stored, and `rd_valid` rises the next cycle.
- `rd_ready` while empty: ignored; no pointer movement.
- `ovf_clear`: clears `overflow` to 0 and `drop_cnt` to 0.
  - If a drop occurs in the same cycle, set wins: `overflow`=1 and `drop_cnt`=1.
- Outputs:
  - `rd_valid = ~empty`.
  - `rd_data = empty ? 8'h00 : mem[rp]` (combinational read).
  - `full`, `empty`, `count` are decoded from the registered count.
- No state machine beyond the pointer/count datapath. Overflow is a two-state flag: CLEAR→SET on drop; SET→CLEAR on `ovf_clear` without a drop.

## Timing

- Reset (rst_n=0 at a rising edge): on the following cycle the outputs are:
  - `wp`=`rp`=0, `count`=0.
  - `empty`=1, `full`=0, `rd_valid`=0, `rd_data`=8'h00.
  - `overflow`=0, `drop_cnt`=0.
- Reset mid-operation discards all stored bytes. `wr_valid` and `rd_ready` are ignored in any cycle where rst_n=0.
- Write latency: push at edge N → `rd_valid`=1 and byte on `rd_data` after edge N, i.e. visible in cycle N+1.
- Pop at edge N → next byte (or `rd_valid`=0) after edge N. Back-to-back pops every cycle are supported.
- `count`, `full`, `empty`, `overflow`, `drop_cnt` all update on the same edge as the causing push/pop/drop/clear.
- Sustained throughput: one push and one pop per cycle concurrently.

## Test plan

- Reset then idle → `empty`=1, `rd_valid`=0, `rd_data`=00, `count`=0, `overflow`=0, `drop_cnt`=0.
- Write 0x41, 0x42, 0x43 with `rd_ready`=0, then hold `rd_ready`=1:
  - `count` goes 1,2,3.
  - `rd_data` reads 41,42,43 on consecutive cycles.
  - `empty` returns 1 after the third pop.
- DEPTH=16: write 0x00..0x0F (→ `full`=1, `count`=16), then write 0xAA, 0xBB with no pop:
  - `overflow`=1, `drop_cnt`=2.
  - Drain yields exactly 0x00..0x0F.
- While full, pulse `wr_valid`(0x55) together with `rd_ready`=1:
  - 0x00 popped, 0x55 accepted, `count` stays 16, `overflow` unchanged.
  - The last byte drained is 0x55.
- Pulse `ovf_clear` alone → `overflow`=0, `drop_cnt`=0. Pulse `ovf_clear` together with a drop → `overflow`=1, `drop_cnt`=1.
- Pointer wrap and reset mid-operation:
  - Stream 40 bytes through with random `rd_ready` and no drops; output order matches input.
  - Then assert `rst_n`=0 with `count`=5 → `count`=0, `rd_valid`=0 next cycle.
